// File: rtl/fop_pkg.sv
// Shared definitions for the Fibonacci-or-Prime detector family and its
// self-test sequencer: sweep FSM states, code width and golden truth table.
package fop_pkg;

    localparam int FOP_W = 4;

    // Bit n set when n is in {0,1,2,3,5,7,8,11,13}.
    localparam logic [15:0] FOP_GOLDEN = 16'h29AF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } fop_sweep_st_t;

endpackage

// File: rtl/fop_B.sv
// Fibonacci-or-Prime detector, behavioural lookup.
// Ports: code (4-bit input code), f (1 when code is Fibonacci or prime).
module fop_B (
    input  logic [3:0] code,
    output logic       f
);

    always_comb begin
        f = 1'b0;
        case (code)
            4'd0, 4'd1, 4'd2, 4'd3,
            4'd5, 4'd7, 4'd8, 4'd11,
            4'd13:   f = 1'b1;
            default: f = 1'b0;
        endcase
    end

endmodule

// File: rtl/fop_D.sv
// Fibonacci-or-Prime detector, dataflow form.
// Ports: code (4-bit input code), f (1 when code is Fibonacci or prime).
module fop_D (
    input  logic [3:0] code,
    output logic       f
);

    logic a, b, c, d;

    assign {a, b, c, d} = code;

    assign f = (~a & ~b)
             | (~a & d)
             | (~b & ~c & ~d)
             | (~b & c & d)
             | (b & ~c & d);

endmodule

// File: rtl/fop_G.sv
// Fibonacci-or-Prime detector, gate-level primitives.
// Ports: code (4-bit input code), f (1 when code is Fibonacci or prime).
module fop_G (
    input  logic [3:0] code,
    output logic       f
);

    logic a, b, c, d;
    logic na, nb, nc, nd;
    logic t0, t1, t2, t3, t4;

    assign {a, b, c, d} = code;

    not g_na (na, a);
    not g_nb (nb, b);
    not g_nc (nc, c);
    not g_nd (nd, d);

    // f = a'b' + a'd + b'c'd' + b'cd + bc'd
    and g_t0 (t0, na, nb);
    and g_t1 (t1, na, d);
    and g_t2 (t2, nb, nc, nd);
    and g_t3 (t3, nb, c, d);
    and g_t4 (t4, b, nc, d);
    or  g_f  (f, t0, t1, t2, t3, t4);

endmodule

// File: rtl/fop_vote_chk.sv
// Compares the three detector outputs against the expected bit.
// Ports: out_g/out_d/out_b (detector outputs), exp_bit (golden), fail.
module fop_vote_chk (
    input  logic out_g,
    input  logic out_d,
    input  logic out_b,
    input  logic exp_bit,
    output logic fail
);

    assign fail = (out_g != exp_bit)
                | (out_d != exp_bit)
                | (out_b != exp_bit);

endmodule

// File: rtl/fop_sweep_ctrl.sv
// Self-test sequencer: sweeps codes 0..15 through the three detectors,
// checks each against GOLDEN and accumulates a pass/fail summary.
// Ports: clk, rst (async high), start, fault_en, fault_idx (inputs);
//        busy, done, pass, err_cnt, fail_mask, first_fail,
//        first_fail_vld, det_in (outputs).
module fop_sweep_ctrl
    import fop_pkg::*;
#(
    parameter int unsigned SETTLE = 1,
    parameter logic [15:0] GOLDEN = FOP_GOLDEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             fault_en,
    input  logic [FOP_W-1:0] fault_idx,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [4:0]       err_cnt,
    output logic [15:0]      fail_mask,
    output logic [FOP_W-1:0] first_fail,
    output logic             first_fail_vld,
    output logic [FOP_W-1:0] det_in
);

    localparam logic [2:0] HOLD_MAX = 3'(SETTLE);

    fop_sweep_st_t    state_q;
    fop_sweep_st_t    state_d;
    logic [2:0]       hold_q;
    logic             fault_en_q;
    logic [FOP_W-1:0] fault_idx_q;

    logic out_g, out_d, out_b, out_bf;
    logic fail;
    logic sample;
    logic last;
    logic [4:0] err_nxt;

    fop_G u_fop_g (.code(det_in), .f(out_g));
    fop_D u_fop_d (.code(det_in), .f(out_d));
    fop_B u_fop_b (.code(det_in), .f(out_b));

    // Injected fault flips only the behavioural detector at one code.
    assign out_bf = out_b ^ (fault_en_q && (det_in == fault_idx_q));

    fop_vote_chk u_vote (
        .out_g   (out_g),
        .out_d   (out_d),
        .out_b   (out_bf),
        .exp_bit (GOLDEN[det_in]),
        .fail    (fail)
    );

    assign sample  = (state_q == DRIVE) && (hold_q == HOLD_MAX);
    assign last    = (det_in == 4'd15);
    assign err_nxt = err_cnt + {4'd0, fail};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = DRIVE;
            end
            DRIVE: begin
                busy = 1'b1;
                if (sample && last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            det_in         <= '0;
            hold_q         <= '0;
            fault_en_q     <= 1'b0;
            fault_idx_q    <= '0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            fail_mask      <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
        end else if (state_q == IDLE && start) begin
            det_in         <= '0;
            hold_q         <= '0;
            fault_en_q     <= fault_en;
            fault_idx_q    <= fault_idx;
            pass           <= 1'b0;
            err_cnt        <= '0;
            fail_mask      <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
        end else if (state_q == DRIVE) begin
            if (sample) begin
                hold_q <= '0;
                if (!last) det_in <= det_in + 4'd1;
                if (fail) begin
                    fail_mask[det_in] <= 1'b1;
                    err_cnt           <= err_nxt;
                    if (!first_fail_vld) begin
                        first_fail     <= det_in;
                        first_fail_vld <= 1'b1;
                    end
                end
                // Verdict includes the final code's own result.
                if (last) pass <= (err_nxt == 5'd0);
            end else begin
                hold_q <= hold_q + 3'd1;
            end
        end
    end

endmodule
